counter_priority_sched: RTL
===========================

Name: counter_priority_sched

Overview:
- Schedules involuntary counter increment/decrement cycles against the timer's memory-cycle boundaries.
- Latches per-counter PINC/MINC request pulses and picks the highest-priority pending request at each T12 end-of-cycle strobe.
- Raises CTROR for the following memory cycle, which steals that cycle from instruction sequencing, and presents the counter address and direction.
- Honours GOJAM (restart) and STOP from the timer block.

Parameters:
NCTR, 8, number of counter request channels (index 0 = highest priority)
AW, 3, counter address width; must equal clog2(NCTR)

Ports:
CLOCK  in  1  system clock
SIM_RST  in  1  asynchronous, active-high reset
T12  in  1  end-of-memory-cycle strobe, exactly one CLOCK wide
GOJAM  in  1  restart; synchronous clear of scheduling state
STOP  in  1  inhibit new counter cycles
PINC  in  NCTR  increment request pulses, one bit per counter
MINC  in  NCTR  decrement request pulses, one bit per counter
OVRUN_CLR  in  1  clears the OVRUN vector
CTROR  out  1  a counter cycle occupies the current memory cycle
CADR  out  AW  address of the counter being serviced
CPLUS  out  1  serviced request is an increment
CMINUS  out  1  serviced request is a decrement
CGNT  out  1  one-CLOCK pulse on the cycle after a grant edge
PEND  out  NCTR  pending vector (pend_plus | pend_minus)
OVRUN  out  NCTR  sticky: a request arrived while the same request was already pending

Behaviour:
- Reset (SIM_RST=1, async): all pend bits, OVRUN, CTROR, CADR, CPLUS, CMINUS, CGNT = 0; state IDLE.
- Capture, every edge, per channel i:
  - np = pend_plus[i] | PINC[i]; nm = pend_minus[i] | MINC[i].
  - If np & nm, both clear (net-zero cancel; no grant, no overrun).
- Overrun: PINC[i] & pend_plus[i] sets OVRUN[i], unless bit i/plus is granted on that same edge. MINC is handled likewise.
  - OVRUN clears only on SIM_RST or OVRUN_CLR.
  - OVRUN_CLR and a new overrun on the same edge: set wins.
- Grant eligibility uses registered pend only. A request arriving on the T12 edge waits for the next T12.
  - Minimum latency: PINC at edge k, T12 at edge k+1 → CTROR=1 after edge k+1.
- State machine (IDLE, CYCLE), evaluated on edges where T12=1:
  - If GOJAM=0, STOP=0 and any pend: go to CYCLE.
    - CADR = lowest pending index; CPLUS/CMINUS from its pend type.
    - Clear that pend bit.
    - CGNT=1 for one CLOCK.
  - Otherwise: go to IDLE; CTROR=CPLUS=CMINUS=0, CADR=0.
  - CTROR=1 exactly while in CYCLE. Outputs hold between T12 strobes.
  - Back-to-back grants are allowed (CYCLE→CYCLE with a new CADR).
- Same-edge regrant: if the granted bit receives a new same-type request on the grant edge, it is re-latched as pending (no overrun).
- GOJAM=1 (any edge, overrides T12):
  - Clear all pend bits, CTROR, CPLUS, CMINUS, CADR, CGNT; state IDLE.
  - Requests on that edge are discarded. OVRUN is kept.
- STOP=1: capture continues; at T12 no grant, and an active CYCLE ends (CTROR falls). Pending requests are serviced after STOP falls.
- T12 with nothing pending: IDLE, no CGNT.

Decomposition:
- Package ctr_sched_pkg: NCTR, AW defaults; state enum {IDLE, CYCLE}; type ctr_idx_t [AW-1:0].
- Sub-module ctr_prio_enc: combinational NCTR-to-AW lowest-index priority encoder with valid output. Instantiated once, on pend_plus | pend_minus.
- Sequencing and capture logic stay in counter_priority_sched.

Test Plan:
- Reset/idle: SIM_RST pulse, T12 every 12 clocks, no requests → all outputs 0, PEND=0, CGNT never asserted.
- Priority: PINC[5] and MINC[2] pulsed together, then two T12s → first CADR=2, CMINUS=1; second CADR=5, CPLUS=1; CTROR high for two consecutive cycles, then 0.
- Cancel/overrun: PINC[3] then MINC[3] before T12 → PEND=0, no grant. PINC[4] twice before T12 → OVRUN=8'h10, single grant CADR=4; OVRUN_CLR → OVRUN=0.
- Same-edge: PINC[1] asserted on the edge with T12 that grants channel 1 → PEND[1] stays 1, OVRUN[1]=0, regranted at the next T12.
- GOJAM mid-CYCLE with PEND=8'h81 → CTROR=0, PEND=0 next clock, OVRUN unchanged, no grant at the next T12.
- STOP: STOP=1 with PINC[0] pending across 3 T12s → no grant, CTROR=0; STOP→0 → grant CADR=0 at the next T12.

Source files
------------

// File: rtl/ctr_sched_pkg.sv
// Shared types and defaults for the involuntary counter scheduler.
// Imported by the priority encoder and the scheduler top.
package ctr_sched_pkg;

    localparam int NCTR_DEF = 8;
    localparam int AW_DEF   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CYCLE = 1'b1
    } state_t;

    typedef logic [AW_DEF-1:0] ctr_idx_t;

endpackage

// File: rtl/ctr_prio_enc.sv
// Lowest-index-wins priority encoder over the pending request vector.
// Channel 0 has the highest priority.
module ctr_prio_enc
    import ctr_sched_pkg::*;
#(
    parameter int NCTR = NCTR_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic [NCTR-1:0] req,
    output logic [AW-1:0]   idx,
    output logic            valid
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NCTR - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = AW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_priority_sched.sv
// Steals memory cycles for counter PINC/MINC requests at T12 boundaries.
// Latches requests, grants the lowest pending channel, tracks overruns.
module counter_priority_sched
    import ctr_sched_pkg::*;
#(
    parameter int NCTR = NCTR_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic            CLOCK,
    input  logic            SIM_RST,
    input  logic            T12,
    input  logic            GOJAM,
    input  logic            STOP,
    input  logic [NCTR-1:0] PINC,
    input  logic [NCTR-1:0] MINC,
    input  logic            OVRUN_CLR,
    output logic            CTROR,
    output logic [AW-1:0]   CADR,
    output logic            CPLUS,
    output logic            CMINUS,
    output logic            CGNT,
    output logic [NCTR-1:0] PEND,
    output logic [NCTR-1:0] OVRUN
);

    state_t          state;
    logic [NCTR-1:0] pend_plus;
    logic [NCTR-1:0] pend_minus;
    logic [NCTR-1:0] ovrun_q;
    logic [AW-1:0]   cadr_q;
    logic            cplus_q;
    logic            cminus_q;
    logic            cgnt_q;

    logic [AW-1:0]   g_idx;
    logic            g_valid;
    logic            grant;
    logic            g_plus;
    logic [NCTR-1:0] g_onehot;
    logic [NCTR-1:0] keep_plus;
    logic [NCTR-1:0] keep_minus;
    logic [NCTR-1:0] np;
    logic [NCTR-1:0] nm;
    logic [NCTR-1:0] cancel;
    logic [NCTR-1:0] ovr_set;

    ctr_prio_enc #(
        .NCTR (NCTR),
        .AW   (AW)
    ) u_enc (
        .req   (pend_plus | pend_minus),
        .idx   (g_idx),
        .valid (g_valid)
    );

    // Eligibility looks only at registered pend, so a same-edge request waits.
    assign grant    = T12 & ~GOJAM & ~STOP & g_valid;
    assign g_plus   = pend_plus[g_idx];
    assign g_onehot = grant ? (NCTR'(1) << g_idx) : '0;

    // Granted bit is retired before capture, so a same-edge request re-latches.
    assign keep_plus  = pend_plus  & ~(g_onehot & {NCTR{g_plus}});
    assign keep_minus = pend_minus & ~(g_onehot & {NCTR{~g_plus}});
    assign np         = keep_plus  | PINC;
    assign nm         = keep_minus | MINC;
    assign cancel     = np & nm;
    assign ovr_set    = ((PINC & keep_plus) | (MINC & keep_minus)) & ~cancel;

    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            ovrun_q <= '0;
        end else begin
            ovrun_q <= (ovrun_q & ~{NCTR{OVRUN_CLR}})
                     | (ovr_set & {NCTR{~GOJAM}});
        end
    end

    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state      <= IDLE;
            pend_plus  <= '0;
            pend_minus <= '0;
            cadr_q     <= '0;
            cplus_q    <= 1'b0;
            cminus_q   <= 1'b0;
            cgnt_q     <= 1'b0;
        end else if (GOJAM) begin
            state      <= IDLE;
            pend_plus  <= '0;
            pend_minus <= '0;
            cadr_q     <= '0;
            cplus_q    <= 1'b0;
            cminus_q   <= 1'b0;
            cgnt_q     <= 1'b0;
        end else begin
            pend_plus  <= np & ~cancel;
            pend_minus <= nm & ~cancel;
            cgnt_q     <= grant;
            if (T12) begin
                if (grant) begin
                    state    <= CYCLE;
                    cadr_q   <= g_idx;
                    cplus_q  <= g_plus;
                    cminus_q <= ~g_plus;
                end else begin
                    state    <= IDLE;
                    cadr_q   <= '0;
                    cplus_q  <= 1'b0;
                    cminus_q <= 1'b0;
                end
            end
        end
    end

    assign CTROR  = (state == CYCLE);
    assign CADR   = cadr_q;
    assign CPLUS  = cplus_q;
    assign CMINUS = cminus_q;
    assign CGNT   = cgnt_q;
    assign PEND   = pend_plus | pend_minus;
    assign OVRUN  = ovrun_q;

endmodule
